// File: rtl/riscv_dmem_resp.sv
// rtl/riscv_dmem_resp.sv - data-memory responder for the RISC-V core load/store port
//
// Purpose:
//   Memory side of the core's data interface. Accepts one request at a time,
//   commits stores with byte-lane masking on the acceptance edge, and answers
//   every request after RD_LATENCY cycles with extended load data or an error.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words stored
//   BASE_ADDR    first byte address served
//   RD_LATENCY   cycles from acceptance to rsp_valid_o (1..7)
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   req_valid_i/req_ready_o   request handshake (ready only while idle)
//   req_we_i           1 = store, 0 = load
//   req_addr_i         byte address
//   req_wdata_i        store data, LSB-aligned
//   req_mem_op_i       funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_rdata_o        extended load data; 0 for stores and errors
//   rsp_err_o          access faulted, nothing was written
//
// Configuration:
//   DMEM_MISALIGN_CHK_EN  defined: misaligned H/HU/W accesses fault.
//                         undefined: low address bits are forced to natural
//                         alignment and the access proceeds.

module riscv_dmem_resp #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_mem_op_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [2:0]  CNT_INIT = 3'((RD_LATENCY > 1) ? RD_LATENCY - 1 : 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  // Request fields captured at acceptance, used when the load is sampled later.
  logic [IDX_W-1:0]  idx_q;
  logic [2:0]        op_q;
  logic [1:0]        lane_q;
  logic              we_q;
  logic              err_q;

  logic [31:0]       mem_q [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [31:0]       req_off;
  logic              req_in_range;
  logic              req_is_h;
  logic              req_is_w;
  logic              req_bad_op;
  logic              req_st_bad;
  logic              req_misalign;
  logic              req_err;
  logic [1:0]        req_lane;
  logic [IDX_W-1:0]  req_idx;

  assign req_off      = req_addr_i - BASE_ADDR;
  // Both bounds are needed: the subtraction wraps for addresses below BASE_ADDR.
  assign req_in_range = (req_addr_i >= BASE_ADDR) && ({1'b0, req_off} < SPAN);
  assign req_is_h     = (req_mem_op_i[1:0] == 2'b01);
  assign req_is_w     = (req_mem_op_i == 3'b010);
  assign req_bad_op   = (req_mem_op_i == 3'b011) || (req_mem_op_i == 3'b110) ||
                        (req_mem_op_i == 3'b111);
  assign req_st_bad   = req_we_i && req_mem_op_i[2];

`ifdef DMEM_MISALIGN_CHK_EN
  assign req_misalign = (req_is_h && req_addr_i[0]) ||
                        (req_is_w && (req_addr_i[1:0] != 2'b00));
`else
  assign req_misalign = 1'b0;
`endif

  assign req_err  = !req_in_range || req_bad_op || req_st_bad || req_misalign;

  // Lane of the lowest byte touched, with the low bits forced to natural
  // alignment (only reachable when misalignment is not reported as an error).
  assign req_lane = req_is_w ? 2'b00 :
                    req_is_h ? {req_addr_i[1], 1'b0} : req_addr_i[1:0];
  assign req_idx  = req_off[IDX_W+1:2];

  // ---------------------------------------------------------------------------
  // Store path: commits on the acceptance edge
  // ---------------------------------------------------------------------------
  logic              accept;
  logic              wr_en;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;

  assign accept = req_valid_i && (state_q == S_IDLE);
  assign wr_en  = rst_n && accept && req_we_i && !req_err;

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = req_wdata_i;
    case (req_mem_op_i[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << req_lane;
        wr_data = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        wr_be   = req_lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata_i[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = req_wdata_i;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem_q[req_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load path: sampled on the edge entering RESP
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] load_ext(input logic [31:0] w,
                                           input logic [2:0]  op,
                                           input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (op)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'h000000, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'h0000, h};
      default: load_ext = w;
    endcase
  endfunction

  // With RD_LATENCY = 1 the sample happens on the acceptance edge itself, so
  // the live request fields are used instead of the captured copies.
  logic              rd_from_req;
  logic [IDX_W-1:0]  rd_idx;
  logic [2:0]        rd_op;
  logic [1:0]        rd_lane;
  logic              rd_we;
  logic              rd_err;
  logic [31:0]       load_data_d;

  assign rd_from_req = (state_q == S_IDLE);
  assign rd_idx      = rd_from_req ? req_idx      : idx_q;
  assign rd_op       = rd_from_req ? req_mem_op_i : op_q;
  assign rd_lane     = rd_from_req ? req_lane     : lane_q;
  assign rd_we       = rd_from_req ? req_we_i     : we_q;
  assign rd_err      = rd_from_req ? req_err      : err_q;

  assign load_data_d = (rd_we || rd_err) ? 32'h0000_0000
                                         : load_ext(mem_q[rd_idx], rd_op, rd_lane);

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
      idx_q       <= '0;
      op_q        <= 3'b000;
      lane_q      <= 2'b00;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            idx_q       <= req_idx;
            op_q        <= req_mem_op_i;
            lane_q      <= req_lane;
            we_q        <= req_we_i;
            err_q       <= req_err;
            req_ready_q <= 1'b0;
            if (RD_LATENCY <= 1) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= load_data_d;
              rsp_err_q   <= req_err;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          // cnt_q reaching zero on this edge is the edge that enters RESP.
          if (cnt_q == 3'd1) begin
            state_q     <= S_RESP;
            cnt_q       <= 3'd0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_data_d;
            rsp_err_q   <= err_q;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
